// File: rtl/spike_event_injector_if.sv
// Purpose: AXI-stream style event channel carrying neuron-index beats into
//          spike_event_injector.
// Signals:
//   tvalid  source -> sink  beat valid
//   tready  sink -> source  beat accepted when tvalid & tready
//   tdata   source -> sink  [W-2:0] neuron index, [W-1] force flag
//   tlast   source -> sink  last beat of the current frame
// Modports: master (event source), slave (injector side).
interface spike_event_injector_if #(
  parameter int unsigned W = 16
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/spike_event_injector.sv
// Purpose: decodes a stream of neuron-index events into per-time-step spike
//          vectors and keeps a T-deep history (spike_in[0] newest) for a
//          neuron block. tlast closes a frame; time_step commits it.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   s              event stream (slave modport of spike_event_injector_if)
//   time_step      one-cycle commit pulse
//   spike_in       T entries of N spike bits, [0] newest ... [T-1] oldest
//   step_done      one-cycle pulse after a commit or an underrun shift
//   index_err      sticky: a beat with index >= N was received
//   underrun_err   sticky: time_step arrived with no closed frame
// Optional feature, macro SPIKE_INJECT_FORCE_EN:
//   force_spike_en / force_spike_neuron_select pulse for one cycle when a
//   beat with tdata[W-1] set is accepted; such beats leave pending alone.
//   Without the macro tdata[W-1] is ignored and the beat is a normal event.
module spike_event_injector #(
  parameter int unsigned N = 16,
  parameter int unsigned T = 4,
  parameter int unsigned W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  spike_event_injector_if.slave  s,
  input  logic                   time_step,
  output logic [T-1:0][N-1:0]    spike_in,
  output logic                   step_done,
  output logic                   index_err,
  output logic                   underrun_err
`ifdef SPIKE_INJECT_FORCE_EN
  ,
  output logic                   force_spike_en,
  output logic [$clog2(N)-1:0]   force_spike_neuron_select
`endif
);

  localparam int unsigned IW = W - 1;
  localparam int unsigned NW = $clog2(N);

  typedef enum logic [1:0] {COLLECT, READY, COMMIT} state_t;

  state_t              state, state_n;
  logic                tready_q;
  logic [N-1:0]        pending, pending_n;
  logic [T-1:0][N-1:0] hist_n;
  logic [IW-1:0]       idx;
  logic                force_bit;
  logic                in_range;
  logic                accept;
  logic                commit;
  logic                underrun;
  logic                done_n;

  assign s.tready = tready_q;
  assign idx      = s.tdata[IW-1:0];
  assign in_range = (idx < IW'(N));
  assign accept   = s.tvalid & tready_q;

`ifdef SPIKE_INJECT_FORCE_EN
  assign force_bit = s.tdata[W-1];
`else
  logic unused_force_bit;
  assign force_bit        = 1'b0;
  assign unused_force_bit = s.tdata[W-1];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end

  // Next state and control strobes
  always_comb begin
    state_n  = state;
    commit   = 1'b0;
    underrun = 1'b0;
    done_n   = 1'b0;
    case (state)
      COLLECT: begin
        // An open frame cannot be committed; shift a blank step instead
        if (time_step) begin
          underrun = 1'b1;
          done_n   = 1'b1;
        end
        if (accept && s.tlast) state_n = READY;
      end
      READY: begin
        if (time_step) begin
          commit  = 1'b1;
          state_n = COMMIT;
        end
      end
      COMMIT: begin
        done_n  = 1'b1;
        state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  // Pending frame accumulation and history shift
  always_comb begin
    pending_n = pending;
    if (accept && !force_bit && in_range) pending_n[NW'(idx)] = 1'b1;
    if (commit) pending_n = '0;

    hist_n    = spike_in;
    hist_n[0] = commit ? pending : '0;
    for (int unsigned k = 1; k < T; k++) hist_n[k] = spike_in[k-1];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tready_q     <= 1'b1;
      pending      <= '0;
      spike_in     <= '0;
      step_done    <= 1'b0;
      index_err    <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      tready_q  <= (state_n == COLLECT);
      pending   <= pending_n;
      step_done <= done_n;
      if (commit || underrun)   spike_in     <= hist_n;
      if (accept && !in_range)  index_err    <= 1'b1;
      if (underrun)             underrun_err <= 1'b1;
    end
  end

`ifdef SPIKE_INJECT_FORCE_EN
  // Force pulse: one cycle, select latched with the pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      force_spike_en            <= 1'b0;
      force_spike_neuron_select <= '0;
    end else begin
      force_spike_en <= accept && force_bit && in_range;
      if (accept && force_bit && in_range) force_spike_neuron_select <= NW'(idx);
    end
  end
`endif

endmodule

// File: tb/tb_spike_event_injector.sv
// Purpose: self-checking bench for spike_event_injector. Directed scenarios
//          followed by random frames, compared against a transaction-level
//          model (pending set, closed flag, history array, sticky flags).
module tb_spike_event_injector;
  localparam int unsigned N  = 16;
  localparam int unsigned T  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned IW = W - 1;

  logic clk = 1'b0;
  logic reset;
  logic time_step;
  logic [T-1:0][N-1:0] spike_in;
  logic step_done, index_err, underrun_err;
`ifdef SPIKE_INJECT_FORCE_EN
  logic force_spike_en;
  logic [$clog2(N)-1:0] force_spike_neuron_select;
`endif

  always #5 clk = ~clk;

  spike_event_injector_if #(.W(W)) s ();

  spike_event_injector #(.N(N), .T(T), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .s            (s),
    .time_step    (time_step),
    .spike_in     (spike_in),
    .step_done    (step_done),
    .index_err    (index_err),
    .underrun_err (underrun_err)
`ifdef SPIKE_INJECT_FORCE_EN
    ,
    .force_spike_en            (force_spike_en),
    .force_spike_neuron_select (force_spike_neuron_select)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [N-1:0] m_hist [T];
  logic [N-1:0] m_pending;
  bit           m_closed;
  bit           m_ierr;
  bit           m_uerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [T*N-1:0] exp_spikes();
    logic [T*N-1:0] r;
    for (int k = 0; k < int'(T); k++) r[k*N +: N] = m_hist[k];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < int'(T); k++) m_hist[k] = '0;
    m_pending = '0;
    m_closed  = 1'b0;
    m_ierr    = 1'b0;
    m_uerr    = 1'b0;
  endtask

  task automatic model_shift(input logic [N-1:0] v);
    for (int k = int'(T) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = v;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".spike_in"}, 64'(spike_in), 64'(exp_spikes()));
    chk({tag, ".index_err"}, 64'(index_err), 64'(m_ierr));
    chk({tag, ".underrun_err"}, 64'(underrun_err), 64'(m_uerr));
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    s.tvalid  = 1'b0;
    s.tlast   = 1'b0;
    s.tdata   = '0;
    time_step = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    check_state(tag);
    chk({tag, ".step_done"}, 64'(step_done), 64'(0));
    chk({tag, ".tready"}, 64'(s.tready), 64'(1));
`ifdef SPIKE_INJECT_FORCE_EN
    chk({tag, ".force_en"}, 64'(force_spike_en), 64'(0));
    chk({tag, ".force_sel"}, 64'(force_spike_neuron_select), 64'(0));
`endif
  endtask

  // One beat on an open frame, optionally together with a time_step pulse
  task automatic beat(input string tag, input int unsigned idx, input bit last,
                      input bit fbit, input bit ts);
    bit treat_force;
    chk({tag, ".tready"}, 64'(s.tready), 64'(!m_closed));
    s.tvalid  = 1'b1;
    s.tdata   = {fbit, IW'(idx)};
    s.tlast   = last;
    time_step = ts;
    @(negedge clk);
    s.tvalid  = 1'b0;
    s.tlast   = 1'b0;
    time_step = 1'b0;
`ifdef SPIKE_INJECT_FORCE_EN
    treat_force = fbit;
`else
    treat_force = 1'b0;
`endif
    if (ts) begin
      model_shift('0);
      m_uerr = 1'b1;
    end
    if (idx >= N) m_ierr = 1'b1;
    else if (!treat_force) m_pending[idx] = 1'b1;
    if (last) m_closed = 1'b1;
    check_state(tag);
    chk({tag, ".step_done"}, 64'(step_done), 64'(ts));
`ifdef SPIKE_INJECT_FORCE_EN
    chk({tag, ".force_en"}, 64'(force_spike_en), 64'(treat_force && idx < N));
    if (treat_force && idx < N)
      chk({tag, ".force_sel"}, 64'(force_spike_neuron_select), 64'(idx));
`endif
  endtask

  // time_step pulse: commit when the frame is closed, otherwise underrun
  task automatic step(input string tag);
    time_step = 1'b1;
    @(negedge clk);
    time_step = 1'b0;
    if (m_closed) begin
      model_shift(m_pending);
      m_pending = '0;
      m_closed  = 1'b0;
      check_state(tag);
      chk({tag, ".done_early"}, 64'(step_done), 64'(0));
      chk({tag, ".tready_commit"}, 64'(s.tready), 64'(0));
      @(negedge clk);
      chk({tag, ".done"}, 64'(step_done), 64'(1));
      chk({tag, ".tready_after"}, 64'(s.tready), 64'(1));
      check_state(tag);
    end else begin
      model_shift('0);
      m_uerr = 1'b1;
      check_state(tag);
      chk({tag, ".done_underrun"}, 64'(step_done), 64'(1));
      chk({tag, ".tready_underrun"}, 64'(s.tready), 64'(1));
      @(negedge clk);
      chk({tag, ".done_clear"}, 64'(step_done), 64'(0));
    end
  endtask

  initial begin
    reset     = 1'b1;
    time_step = 1'b0;
    s.tvalid  = 1'b0;
    s.tlast   = 1'b0;
    s.tdata   = '0;
    model_clear();

    // Basic frame {3, 7, 0/tlast}
    do_reset("t1.reset");
    beat("t1.b3", 3, 1'b0, 1'b0, 1'b0);
    beat("t1.b7", 7, 1'b0, 1'b0, 1'b0);
    beat("t1.b0", 0, 1'b1, 1'b0, 1'b0);
    step("t1.step");
    chk("t1.spike0", 64'(spike_in[0]), 64'(16'h0089));

    // Five single-event frames through a 4-deep history
    do_reset("t2.reset");
    for (int i = 0; i < 5; i++) begin
      beat("t2.beat", i, 1'b1, 1'b0, 1'b0);
      step("t2.step");
    end
    chk("t2.history", 64'(spike_in), {16'h0002, 16'h0004, 16'h0008, 16'h0010});

    // Closed frame holds off the stream until time_step
    do_reset("t3.reset");
    beat("t3.b2", 2, 1'b0, 1'b0, 1'b0);
    beat("t3.b11", 11, 1'b1, 1'b0, 1'b0);
    s.tvalid = 1'b1;
    s.tdata  = 16'd5;
    s.tlast  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3.tready_held", 64'(s.tready), 64'(0));
    end
    s.tvalid = 1'b0;
    s.tlast  = 1'b0;
    step("t3.step");
    chk("t3.spike0", 64'(spike_in[0]), 64'(16'h0804));

    // Underrun mid-frame, then tlast coinciding with time_step
    do_reset("t4.reset");
    beat("t4.b5", 5, 1'b0, 1'b0, 1'b0);
    step("t4.underrun");
    chk("t4.spike0_zero", 64'(spike_in[0]), 64'(0));
    chk("t4.uerr", 64'(underrun_err), 64'(1));
    beat("t4.b9_ts", 9, 1'b1, 1'b0, 1'b1);
    step("t4.commit");
    chk("t4.spike0", 64'(spike_in[0]), 64'(16'h0220));

    // Out-of-range index, then reset mid-frame
    do_reset("t5.reset");
    beat("t5.b2", 2, 1'b0, 1'b0, 1'b0);
    beat("t5.b20", 20, 1'b0, 1'b0, 1'b0);
    chk("t5.ierr", 64'(index_err), 64'(1));
    beat("t5.b4", 4, 1'b1, 1'b0, 1'b0);
    step("t5.step");
    chk("t5.spike0", 64'(spike_in[0]), 64'(16'h0014));
    beat("t5.b6", 6, 1'b0, 1'b0, 1'b0);
    do_reset("t5.midreset");
    beat("t5.b1", 1, 1'b1, 1'b0, 1'b0);
    step("t5.step2");
    chk("t5.spike0_after_reset", 64'(spike_in[0]), 64'(16'h0002));

    // Force-flag beat 0x800A
    do_reset("t6.reset");
    beat("t6.force10", 10, 1'b0, 1'b1, 1'b0);
    beat("t6.b3", 3, 1'b1, 1'b0, 1'b0);
    step("t6.step");
`ifdef SPIKE_INJECT_FORCE_EN
    chk("t6.spike0", 64'(spike_in[0]), 64'(16'h0008));
    chk("t6.force_off", 64'(force_spike_en), 64'(0));
`else
    chk("t6.spike0", 64'(spike_in[0]), 64'(16'h0408));
`endif

    // Random frames, underruns and coincident tlast/time_step
    do_reset("rnd.reset");
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (m_closed) step("rnd.step");
      else if (r == 0) step("rnd.underrun");
      else if (r == 1) beat("rnd.beat_ts", $urandom_range(0, N + 3), 1'b1, 1'b0, 1'b1);
      else beat("rnd.beat", $urandom_range(0, N + 3), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
